// File: rtl/mux81_sched_pkg.sv
// Shared types and constants for the eight-way round-robin mux scheduler.
package mux81_sched_pkg;

  localparam int NREQ  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_t;

  function automatic logic [NREQ-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux81_sched_pick.sv
// Combinational round-robin picker: first set request at or after ptr, modulo 8.
module rr_pick8
  import mux81_sched_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [NREQ-1:0]  rot;
  logic [SEL_W-1:0] off;

  // Rotate so bit 0 of rot is channel ptr; the lowest set bit is then the winner.
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
  end

  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SEL_W'(i);
      end
    end
  end

  assign any = |req;
  assign idx = ptr + off;

endmodule

// File: rtl/mux81_sched.sv
// Round-robin owner of one 8:1 select datapath with bounded hold time.
module mux81_sched
  import mux81_sched_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             valid,
  output logic             timeout,
  output logic             dbg_state,
  output logic [SEL_W-1:0] dbg_ptr
);

  localparam int                CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_HOLD - 1);

  // Handshake: a requester holds req[i] high until it sees gnt[i]; it owns the
  // mux while gnt[i] is high and ends ownership by pulsing done or dropping
  // req[i]. The grant is taken away after MAX_HOLD cycles regardless.

  sched_state_t     state, state_d;
  logic [SEL_W-1:0] ptr, ptr_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [NREQ-1:0]  gnt_d;
  logic [SEL_W-1:0] sel_d;
  logic             valid_d;
  logic             timeout_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             at_limit;
  logic             owner_req;
  logic             release_now;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign at_limit    = (cnt == CNT_LIMIT);
  assign owner_req   = req[sel];
  assign release_now = done || !owner_req || at_limit;

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    cnt_d     = cnt;
    gnt_d     = gnt;
    sel_d     = sel;
    valid_d   = valid;
    timeout_d = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          gnt_d   = sel_onehot(pick_idx);
          sel_d   = pick_idx;
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d   = IDLE;
          gnt_d     = '0;
          valid_d   = 1'b0;
          ptr_d     = sel + SEL_W'(1);
          // A pulse only when the limit alone forced the release.
          timeout_d = at_limit && !done && owner_req;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      sel     <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      valid   <= valid_d;
      timeout <= timeout_d;
    end
  end

  assign dbg_state = (state == GRANT);
  assign dbg_ptr   = ptr;

endmodule

// File: tb/tb_mux81_sched.sv
// Self-checking bench for mux81_sched: two instances (MAX_HOLD 16 and 4) against a cycle model.
module tb_mux81_sched;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;

  logic [7:0] gnt16, gnt4;
  logic [2:0] sel16, sel4;
  logic       valid16, valid4;
  logic       tmo16, tmo4;
  logic       st16, st4;
  logic [2:0] ptr16, ptr4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per instance: owner channel (-1 when free),
  // cycles held so far including the current one, round-robin pointer.
  int m_owner[2];
  int m_held[2];
  int m_ptr[2];
  int m_sel[2];
  bit m_tmo[2];
  int m_max[2] = '{16, 4};

  mux81_sched #(.MAX_HOLD(16)) u_dut16 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt16), .sel(sel16), .valid(valid16), .timeout(tmo16),
    .dbg_state(st16), .dbg_ptr(ptr16)
  );

  mux81_sched #(.MAX_HOLD(4)) u_dut4 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt4), .sel(sel4), .valid(valid4), .timeout(tmo4),
    .dbg_state(st4), .dbg_ptr(ptr4)
  );

  logic [16:0] obs16, obs4;
  assign obs16 = {gnt16, sel16, valid16, tmo16, st16, ptr16};
  assign obs4  = {gnt4, sel4, valid4, tmo4, st4, ptr4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_step(input logic [7:0] r, input logic d, input logic rs);
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        m_owner[k] = -1; m_held[k] = 0; m_ptr[k] = 0; m_sel[k] = 0; m_tmo[k] = 0;
      end else if (m_owner[k] < 0) begin
        m_tmo[k] = 0;
        for (int i = 0; i < 8; i++) begin
          int c;
          c = (m_ptr[k] + i) % 8;
          if (r[c] && m_owner[k] < 0) begin
            m_owner[k] = c; m_sel[k] = c; m_held[k] = 1;
          end
        end
      end else if (d || !r[m_owner[k]] || m_held[k] == m_max[k]) begin
        m_tmo[k]   = (m_held[k] == m_max[k]) && !d && r[m_owner[k]];
        m_ptr[k]   = (m_owner[k] + 1) % 8;
        m_owner[k] = -1;
      end else begin
        m_held[k] = m_held[k] + 1;
        m_tmo[k]  = 0;
      end
    end
  endfunction

  function automatic logic [16:0] exp_vec(input int k);
    logic [7:0] g;
    logic       busy;
    busy = (m_owner[k] >= 0);
    g    = busy ? (8'h01 << m_owner[k]) : 8'h00;
    return {g, 3'(m_sel[k]), busy, m_tmo[k], busy, 3'(m_ptr[k])};
  endfunction

  task automatic tick(input logic [7:0] r, input logic d, input logic rs);
    req  = r;
    done = d;
    rst  = rs;
    @(posedge clk);
    model_step(r, d, rs);
    #1;
  endtask

  task automatic test_reset();
    tick(8'h00, 1'b0, 1'b1);
    tick(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick(8'h00, 1'b0, 1'b0);
      n_checks++;
      if (obs16 !== 17'h0) begin
        n_fail++;
        $display("FAIL reset_idle16 cyc=%0d got=%h exp=%h", c, obs16, 17'h0);
      end
      n_checks++;
      if (obs4 !== 17'h0) begin
        n_fail++;
        $display("FAIL reset_idle4 cyc=%0d got=%h exp=%h", c, obs4, 17'h0);
      end
    end
  endtask

  task automatic test_alternate();
    int  grants;
    int  idle_run;
    int  hold_run;
    logic prev_valid;
    grants = 0; idle_run = 0; hold_run = 0; prev_valid = 1'b0;
    tick(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 15; c++) begin
      tick(8'h81, (m_owner[0] >= 0 && m_held[0] == 2), 1'b0);
      n_checks++;
      if (obs16 !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL alt_model16 cyc=%0d got=%h exp=%h", c, obs16, exp_vec(0));
      end
      n_checks++;
      if (obs4 !== exp_vec(1)) begin
        n_fail++;
        $display("FAIL alt_model4 cyc=%0d got=%h exp=%h", c, obs4, exp_vec(1));
      end
      if (valid16 && !prev_valid) begin
        n_checks++;
        if (sel16 !== ((grants % 2 == 0) ? 3'd0 : 3'd7)) begin
          n_fail++;
          $display("FAIL alt_order grant=%0d got sel=%0d exp=%0d", grants, sel16,
                   (grants % 2 == 0) ? 0 : 7);
        end
        if (grants > 0) begin
          n_checks++;
          if (idle_run != 1) begin
            n_fail++;
            $display("FAIL alt_gap grant=%0d got idle=%0d exp=1", grants, idle_run);
          end
        end
        grants++;
        idle_run = 0;
        hold_run = 1;
      end else if (valid16) begin
        hold_run++;
      end else begin
        if (prev_valid) begin
          n_checks++;
          if (hold_run != 2) begin
            n_fail++;
            $display("FAIL alt_len got=%0d exp=2", hold_run);
          end
        end
        idle_run++;
      end
      prev_valid = valid16;
    end
    n_checks++;
    if (grants != 5) begin
      n_fail++;
      $display("FAIL alt_count got=%0d exp=5", grants);
    end
  endtask

  task automatic test_wrap();
    tick(8'h00, 1'b0, 1'b1);
    tick(8'h40, 1'b0, 1'b0);
    tick(8'h40, 1'b1, 1'b0);
    n_checks++;
    if ({gnt16, ptr16} !== {8'h00, 3'd7}) begin
      n_fail++;
      $display("FAIL wrap_ptr got gnt=%h ptr=%0d exp gnt=00 ptr=7", gnt16, ptr16);
    end
    tick(8'h41, 1'b0, 1'b0);
    n_checks++;
    if ({gnt16, sel16} !== {8'h01, 3'd0}) begin
      n_fail++;
      $display("FAIL wrap_ch0 got gnt=%h sel=%0d exp gnt=01 sel=0", gnt16, sel16);
    end
    tick(8'h41, 1'b1, 1'b0);
    tick(8'h41, 1'b0, 1'b0);
    n_checks++;
    if ({gnt4, sel4} !== {8'h40, 3'd6}) begin
      n_fail++;
      $display("FAIL wrap_ch6 got gnt=%h sel=%0d exp gnt=40 sel=6", gnt4, sel4);
    end
  endtask

  task automatic test_timeout();
    int pulses;
    logic [7:0] eg;
    pulses = 0;
    tick(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 11; c++) begin
      tick(8'h04, 1'b0, 1'b0);
      eg = (c == 4 || c == 9) ? 8'h00 : 8'h04;
      n_checks++;
      if ({gnt4, tmo4} !== {eg, (c == 4 || c == 9)}) begin
        n_fail++;
        $display("FAIL tmo_pattern4 cyc=%0d got gnt=%h tmo=%b exp gnt=%h tmo=%b", c, gnt4, tmo4,
                 eg, (c == 4 || c == 9));
      end
      n_checks++;
      if ({gnt16, tmo16} !== {8'h04, 1'b0}) begin
        n_fail++;
        $display("FAIL tmo_hold16 cyc=%0d got gnt=%h tmo=%b exp gnt=04 tmo=0", c, gnt16, tmo16);
      end
      if (tmo4) pulses++;
    end
    n_checks++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL tmo_pulses got=%0d exp=2", pulses);
    end
    // Keep the 16-deep instance running until its own limit fires.
    for (int c = 11; c < 17; c++) begin
      tick(8'h04, 1'b0, 1'b0);
      n_checks++;
      if (obs16 !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL tmo_model16 cyc=%0d got=%h exp=%h", c, obs16, exp_vec(0));
      end
    end
    n_checks++;
    if ({gnt16, tmo16} !== {8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL tmo_limit16 got gnt=%h tmo=%b exp gnt=00 tmo=1", gnt16, tmo16);
    end
  endtask

  task automatic test_withdraw();
    tick(8'h00, 1'b0, 1'b1);
    tick(8'h08, 1'b0, 1'b0);
    n_checks++;
    if ({gnt16, gnt4} !== {8'h08, 8'h08}) begin
      n_fail++;
      $display("FAIL wd_grant got %h/%h exp 08/08", gnt16, gnt4);
    end
    tick(8'h08, 1'b0, 1'b0);
    tick(8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({gnt16, valid16, tmo16, ptr16, sel16} !== {8'h00, 1'b0, 1'b0, 3'd4, 3'd3}) begin
      n_fail++;
      $display("FAIL wd_release got gnt=%h v=%b tmo=%b ptr=%0d sel=%0d exp 00/0/0/4/3",
               gnt16, valid16, tmo16, ptr16, sel16);
    end
  endtask

  task automatic test_reset_mid();
    tick(8'h00, 1'b0, 1'b1);
    tick(8'h20, 1'b0, 1'b0);
    tick(8'h20, 1'b0, 1'b0);
    n_checks++;
    if ({gnt16, sel16} !== {8'h20, 3'd5}) begin
      n_fail++;
      $display("FAIL rm_grant got gnt=%h sel=%0d exp gnt=20 sel=5", gnt16, sel16);
    end
    tick(8'h20, 1'b0, 1'b1);
    n_checks++;
    if (obs16 !== 17'h0 || obs4 !== 17'h0) begin
      n_fail++;
      $display("FAIL rm_reset got %h/%h exp 0/0", obs16, obs4);
    end
    tick(8'h21, 1'b0, 1'b0);
    n_checks++;
    if ({gnt16, sel16} !== {8'h01, 3'd0}) begin
      n_fail++;
      $display("FAIL rm_regrant got gnt=%h sel=%0d exp gnt=01 sel=0", gnt16, sel16);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       d;
    logic       rs;
    r = 8'h00;
    tick(8'h00, 1'b0, 1'b1);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
      d  = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 149) == 0);
      tick(r, d, rs);
      n_checks++;
      if (obs16 !== exp_vec(0)) begin
        n_fail++;
        $display("FAIL rand_model16 cyc=%0d req=%h got=%h exp=%h", c, r, obs16, exp_vec(0));
      end
      n_checks++;
      if (obs4 !== exp_vec(1)) begin
        n_fail++;
        $display("FAIL rand_model4 cyc=%0d req=%h got=%h exp=%h", c, r, obs4, exp_vec(1));
      end
      n_checks++;
      if (valid4 !== (|gnt4) || valid16 !== (|gnt16)) begin
        n_fail++;
        $display("FAIL rand_valid cyc=%0d got v=%b%b g=%h/%h", c, valid16, valid4, gnt16, gnt4);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;
    test_reset();
    test_alternate();
    test_wrap();
    test_timeout();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
